// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit bridging the execute stage to an OBI-style data port.
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic        lsu_busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        WAIT_RVALID = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;
    localparam logic [1:0] TYPE_ILL  = 2'b11;

    state_t      state;
    logic [1:0]  addr_lo_q;
    logic        we_q;
    logic [1:0]  type_q;
    logic        sign_ext_q;

    logic        misaligned;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] rdata_shifted;
    logic [31:0] load_fmt;

    always_comb begin
        misaligned = 1'b0;
        case (lsu_type_i)
            TYPE_HALF: misaligned = lsu_addr_i[0];
            TYPE_WORD: misaligned = (lsu_addr_i[1:0] != 2'b00);
            TYPE_ILL:  misaligned = 1'b1;
            default:   misaligned = 1'b0;
        endcase
    end

    // Request-side formatting: byte enables and lane-replicated store data.
    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = lsu_wdata_i;
        case (lsu_type_i)
            TYPE_BYTE: begin
                be_fmt    = 4'b0001 << lsu_addr_i[1:0];
                wdata_fmt = {4{lsu_wdata_i[7:0]}};
            end
            TYPE_HALF: begin
                be_fmt    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_fmt = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = lsu_wdata_i;
            end
        endcase
    end

    // Response-side formatting uses the latched offset, not the live address.
    always_comb begin
        rdata_shifted = data_rdata_i >> {addr_lo_q, 3'b000};
        load_fmt      = rdata_shifted;
        case (type_q)
            TYPE_BYTE: load_fmt = {{24{sign_ext_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            TYPE_HALF: load_fmt = {{16{sign_ext_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default:   load_fmt = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            addr_lo_q    <= 2'b00;
            we_q         <= 1'b0;
            type_q       <= 2'b00;
            sign_ext_q   <= 1'b0;
            lsu_rdata_o  <= 32'h0;
            lsu_rvalid_o <= 1'b0;
            lsu_err_o    <= 1'b0;
            lsu_busy_o   <= 1'b0;
            data_req_o   <= 1'b0;
            data_addr_o  <= 32'h0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_wdata_o <= 32'h0;
        end else begin
            lsu_rvalid_o <= 1'b0;
            lsu_err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (misaligned) begin
                            lsu_err_o <= 1'b1;
                        end else begin
                            addr_lo_q    <= lsu_addr_i[1:0];
                            we_q         <= lsu_we_i;
                            type_q       <= lsu_type_i;
                            sign_ext_q   <= lsu_sign_ext_i;
                            data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                            data_we_o    <= lsu_we_i;
                            data_be_o    <= be_fmt;
                            data_wdata_o <= wdata_fmt;
                            data_req_o   <= 1'b1;
                            lsu_busy_o   <= 1'b1;
                            state        <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state      <= WAIT_RVALID;
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        lsu_rdata_o  <= we_q ? 32'h0 : load_fmt;
                        lsu_rvalid_o <= 1'b1;
                        lsu_busy_o   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    data_req_o <= 1'b0;
                    lsu_busy_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o;
    logic        lsu_err_o;
    logic        lsu_busy_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_type_i     (lsu_type_i),
        .lsu_sign_ext_i (lsu_sign_ext_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_err_o      (lsu_err_o),
        .lsu_busy_o     (lsu_busy_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_bad(input logic [31:0] addr, input logic [1:0] typ);
        if (typ == 2'b11) return 1'b1;
        return (addr % (32'd1 << typ)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] typ);
        int nbytes = 1 << typ;
        int mask   = ((1 << nbytes) - 1) << addr[1:0];
        return mask[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [1:0] typ);
        if (typ == 2'b00) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (typ == 2'b01) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] typ, input logic sext);
        int          nbits = 8 << typ;
        logic [31:0] v     = word >> (8 * off);
        logic [31:0] mask;
        if (nbits >= 32) return v;
        mask = (32'h1 << nbits) - 32'h1;
        v    = v & mask;
        if (sext && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        lsu_req_i      = 1'b0;
        lsu_we_i       = 1'b0;
        lsu_type_i     = 2'b00;
        lsu_sign_ext_i = 1'b0;
        lsu_addr_i     = 32'h0;
        lsu_wdata_i    = 32'h0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rdata"},  lsu_rdata_o,  32'h0);
        check_eq({tag, "_rvalid"}, {31'h0, lsu_rvalid_o}, 32'h0);
        check_eq({tag, "_err"},    {31'h0, lsu_err_o},    32'h0);
        check_eq({tag, "_busy"},   {31'h0, lsu_busy_o},   32'h0);
        check_eq({tag, "_req"},    {31'h0, data_req_o},   32'h0);
        check_eq({tag, "_addr"},   data_addr_o,  32'h0);
        check_eq({tag, "_we"},     {31'h0, data_we_o},    32'h0);
        check_eq({tag, "_be"},     {28'h0, data_be_o},    32'h0);
        check_eq({tag, "_wdata"},  data_wdata_o, 32'h0);
    endtask

    // Legal access; gw/rw are grant and rvalid wait cycles, latency is 3+gw+rw.
    task automatic run_access(input logic we, input logic [1:0] typ, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gw, input int rw, input logic [31:0] rdata);
        int          last = 3 + gw + rw;
        bit          in_req;
        logic [31:0] exp_r = we ? 32'h0 : model_load(rdata, addr[1:0], typ, sext);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sext;
        lsu_addr_i = addr; lsu_wdata_i = wdata;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(posedge clk_i); #1;
            in_req = (cyc <= 1 + gw);
            check_eq("data_req", {31'h0, data_req_o}, {31'h0, in_req});
            check_eq("busy", {31'h0, lsu_busy_o}, {31'h0, (cyc < last)});
            check_eq("rvalid", {31'h0, lsu_rvalid_o}, {31'h0, (cyc == last)});
            check_eq("err_idle", {31'h0, lsu_err_o}, 32'h0);
            if (in_req) begin
                check_eq("addr", data_addr_o, addr & ~32'h3);
                check_eq("be", {28'h0, data_be_o}, {28'h0, model_be(addr, typ)});
                check_eq("wdata", data_wdata_o, model_wdata(wdata, typ));
                check_eq("we", {31'h0, data_we_o}, {31'h0, we});
            end
            if (cyc == last) check_eq("rdata", lsu_rdata_o, exp_r);
            // Requests while busy must be ignored, whatever they look like.
            lsu_req_i      = (cyc < last) ? 1'($urandom % 2) : 1'b0;
            lsu_we_i       = 1'($urandom);
            lsu_type_i     = 2'($urandom);
            lsu_sign_ext_i = 1'($urandom);
            lsu_addr_i     = $urandom;
            lsu_wdata_i    = $urandom;
            data_gnt_i     = (cyc == 1 + gw);
            if (cyc == 2 + gw + rw) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = rdata;
            end else begin
                data_rvalid_i = in_req ? 1'($urandom % 2) : 1'b0;
                data_rdata_i  = $urandom;
            end
        end
        idle_inputs();
        @(posedge clk_i); #1;
        check_eq("rvalid_after", {31'h0, lsu_rvalid_o}, 32'h0);
        check_eq("busy_after", {31'h0, lsu_busy_o}, 32'h0);
    endtask

    task automatic run_error(input logic we, input logic [1:0] typ, input logic [31:0] addr);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ; lsu_addr_i = addr;
        lsu_wdata_i = $urandom; lsu_sign_ext_i = 1'($urandom);
        @(posedge clk_i); #1;
        idle_inputs();
        check_eq("err_pulse", {31'h0, lsu_err_o}, 32'h1);
        check_eq("err_req", {31'h0, data_req_o}, 32'h0);
        check_eq("err_busy", {31'h0, lsu_busy_o}, 32'h0);
        check_eq("err_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
        @(posedge clk_i); #1;
        check_eq("err_end", {31'h0, lsu_err_o}, 32'h0);
        check_eq("err_req2", {31'h0, data_req_o}, 32'h0);
        check_eq("err_busy2", {31'h0, lsu_busy_o}, 32'h0);
    endtask

    // Reset in REQ (stage 1) or WAIT_RVALID (stage 2), then a late rvalid that must be ignored.
    task automatic reset_abort(input int stage);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b10; lsu_addr_i = 32'h3000;
        @(posedge clk_i); #1;
        lsu_req_i  = 1'b0;
        data_gnt_i = (stage == 2);
        if (stage == 2) begin
            @(posedge clk_i); #1;
            data_gnt_i = 1'b0;
        end
        check_eq("pre_rst_busy", {31'h0, lsu_busy_o}, 32'h1);
        check_eq("pre_rst_req", {31'h0, data_req_o}, {31'h0, (stage == 1)});
        rst_ni = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0;
        check_all_zero("late_rvalid");
        @(posedge clk_i); #1;
        check_eq("late_rvalid2", {31'h0, lsu_rvalid_o}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  t;
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;

        run_access(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0, 0, 32'hDEAD_BEEF);
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 0, 0, 32'h8012_3456);
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h8012_3456);
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'h5555_AAAA);
        run_error(1'b0, 2'b10, 32'h0000_1002);
        run_error(1'b0, 2'b11, 32'h0000_1000);
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 3, 0, 32'h0BAD_F00D);
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0, 1, 2, 32'h8001_7FFF);
        reset_abort(2);
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0, 0, 32'h1357_9BDF);
        reset_abort(1);
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0, 0, 1, 32'h2468_ACE0);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            t = 2'($urandom);
            if (model_bad(a, t))
                run_error(1'($urandom), t, a);
            else
                run_access(1'($urandom), t, 1'($urandom), a, $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; address and data width fixed at 32.
REQ-002 Clocking: one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 lsu_req_i  in  1  one-cycle pulse from the execute stage requesting a memory access (ALU_RESULT_SEL_LSU path).
REQ-006 lsu_we_i  in  1  1 = store, 0 = load.
REQ-007 lsu_type_i  in  2  access size (funct3[1:0]): 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 lsu_sign_ext_i  in  1  1 = sign-extend load result (LB/LH), 0 = zero-extend (LBU/LHU).
REQ-009 lsu_addr_i  in  32  effective address computed by the ALU (ALU_ADD).
REQ-010 lsu_wdata_i  in  32  store data (rs2).
REQ-011 lsu_rdata_o  out  32  aligned and extended load result; 0 for stores.
REQ-012 lsu_rvalid_o  out  1  one-cycle completion pulse for a load or store.
REQ-013 lsu_err_o  out  1  one-cycle pulse on a misaligned or illegal-size request.
REQ-014 lsu_busy_o  out  1  high whenever the FSM is not IDLE; used by the pipeline to stall.
REQ-015 data_req_o  out  1  memory request (OBI-style).
REQ-016 data_gnt_i  in  1  memory grant.
REQ-017 data_addr_o  out  32  word-aligned address: {addr[31:2], 2'b00}.
REQ-018 data_we_o  out  1  memory write enable.
REQ-019 data_be_o  out  4  byte enables.
REQ-020 data_wdata_o  out  32  lane-replicated store data.
REQ-021 data_rvalid_i  in  1  memory response valid.
REQ-022 data_rdata_i  in  32  memory read word.

Function
REQ-023 The FSM SHALL have three states: IDLE, REQ and WAIT_RVALID.
REQ-024 In IDLE, an aligned lsu_req_i SHALL latch addr, we, type, sign_ext and formatted wdata/be, and SHALL transition to REQ on the next edge.
REQ-025 A request is misaligned when type=01 and addr[0]=1, or type=10 and addr[1:0]!=0, or type=11; it SHALL produce lsu_err_o=1 for exactly the next cycle, issue no memory request, and leave the FSM in IDLE.
REQ-026 lsu_req_i asserted outside IDLE SHALL be ignored.
REQ-027 In REQ, data_req_o SHALL be 1, with data_addr_o/we/be/wdata driven from the latched registers and held stable until data_gnt_i=1.
REQ-028 On data_gnt_i=1 in REQ, the FSM SHALL transition to WAIT_RVALID; data_req_o SHALL be 0 in every state other than REQ.
REQ-029 data_rvalid_i SHALL be sampled only in WAIT_RVALID and SHALL be ignored in IDLE and REQ.
REQ-030 On data_rvalid_i=1 in WAIT_RVALID, the unit SHALL register lsu_rdata_o, pulse lsu_rvalid_o for exactly the next cycle, and return to IDLE.
REQ-031 Zero-wait latency from the lsu_req_i cycle to lsu_rvalid_o SHALL be 3 cycles; each gnt or rvalid wait cycle adds 1.
REQ-032 Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
REQ-033 Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata unchanged.
REQ-034 Load data: shift data_rdata_i right by 8*addr[1:0], select 8, 16 or 32 bits, then sign- or zero-extend per lsu_sign_ext_i; word loads ignore lsu_sign_ext_i.
REQ-035 On store completion, lsu_rdata_o SHALL be 0.
REQ-036 lsu_rvalid_o and lsu_err_o SHALL never be asserted in the same cycle.

Reset
REQ-037 While rst_ni=0, the FSM SHALL be IDLE and all outputs and latched registers SHALL be 0, asynchronously.
REQ-038 Reset asserted mid-transaction SHALL abort it: data_req_o drops immediately, and a late data_rvalid_i after release SHALL be ignored (IDLE).

Verification
REQ-039 LW addr 0x1000, gnt in REQ cycle, rvalid next cycle with rdata 0xDEADBEEF -> data_addr_o 0x1000, be 1111; lsu_rdata_o 0xDEADBEEF with lsu_rvalid_o 3 cycles after request.
REQ-040 LB addr 0x1003, rdata 0x80123456 -> lsu_rdata_o 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-041 SH addr 0x2002, wdata 0x1234ABCD -> data_be_o 1100, data_wdata_o 0xABCDABCD, data_we_o 1; lsu_rdata_o 0 at completion.
REQ-042 LW addr 0x1002, and separately type=11 -> lsu_err_o one-cycle pulse, data_req_o never asserted, lsu_busy_o stays 0.
REQ-043 gnt withheld 3 cycles -> data_req_o, data_addr_o and data_be_o stable for 4 cycles, lsu_busy_o high, new lsu_req_i ignored, and latency becomes 6 cycles.
REQ-044 Reset pulse in WAIT_RVALID, followed by rvalid 2 cycles after release -> all outputs 0, no lsu_rvalid_o, and the next LW completes normally.
